// File: rtl/gj_axis_uart_tx_fifo.sv
// rtl/gj_axis_uart_tx_fifo.sv - AXI-Stream UART transmitter with character FIFO
// Per-character framing (data bits, parity, stop bits, idle gap) is latched when the character leaves the FIFO.
module gj_axis_uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DIV_W-1:0]                  cfg_div,
  input  logic [3:0]                        cfg_dbits,
  input  logic [1:0]                        cfg_parity,
  input  logic                              cfg_stop2,
  input  logic [15:0]                       cfg_gap,
  input  logic                              tx_tvalid,
  output logic                              tx_tready,
  input  logic [DATA_W-1:0]                 tx_tdata,
  input  logic                              tx_tlast,
  output logic                              tx,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);
  localparam logic [3:0] DMAX = 4'(DATA_W);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;

  state_t            state;
  logic [DATA_W:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              ready_en;
  logic              push, pop;
  logic [DATA_W-1:0] head_data, masked;
  logic              head_last, par_calc;
  logic [3:0]        dbits_c;

  logic [DIV_W-1:0]  baud_cnt, l_div;
  logic [15:0]       bit_cnt, l_gap;
  logic [DATA_W-1:0] shreg;
  logic [3:0]        l_dbits;
  logic [1:0]        l_par;
  logic              l_stop2, lat_last, par_bit;
  logic              bit_end, stop_done, gap_go, gap_done, char_done;

  assign tx_tready = ready_en && (fifo_level != FULL);
  assign push      = tx_tvalid && tx_tready;
  assign busy      = (fifo_level != '0) || (state != IDLE);
  assign head_data = mem[rd_ptr][DATA_W-1:0];
  assign head_last = mem[rd_ptr][DATA_W];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {tx_tlast, tx_tdata};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      ready_en   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Clamp the data-bit count and precompute parity of the head character
  always_comb begin
    dbits_c = cfg_dbits;
    if (cfg_dbits < 4'd5)     dbits_c = 4'd5;
    else if (cfg_dbits > DMAX) dbits_c = DMAX;
    masked = '0;
    for (int i = 0; i < DATA_W; i++) masked[i] = head_data[i] && (i < int'(dbits_c));
    case (cfg_parity)
      2'b01:   par_calc = ~^masked;
      2'b10:   par_calc = ^masked;
      default: par_calc = 1'b1;
    endcase
  end

  assign bit_end   = (baud_cnt == l_div);
  assign stop_done = (state == STOP) && bit_end && (!l_stop2 || (bit_cnt != 16'd0));
  assign gap_go    = lat_last && (l_gap != 16'd0);
  assign gap_done  = (state == GAP) && bit_end && (bit_cnt == l_gap - 16'd1);
  assign char_done = (stop_done && !gap_go) || gap_done;
  assign pop       = (fifo_level != '0) && ((state == IDLE) || char_done);

  // tx is registered from the current state, so the line trails the FSM by one clock
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      l_div    <= '0;
      l_dbits  <= 4'd5;
      l_par    <= 2'b00;
      l_stop2  <= 1'b0;
      l_gap    <= '0;
      lat_last <= 1'b0;
      par_bit  <= 1'b0;
    end else begin
      case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= shreg[0];
        PARITY:  tx <= par_bit;
        default: tx <= 1'b1;
      endcase
      baud_cnt <= ((state == IDLE) || bit_end) ? '0 : baud_cnt + DIV_W'(1);
      if (pop) begin
        state    <= START;
        bit_cnt  <= '0;
        shreg    <= head_data;
        lat_last <= head_last;
        par_bit  <= par_calc;
        l_div    <= cfg_div;
        l_dbits  <= dbits_c;
        l_par    <= cfg_parity;
        l_stop2  <= cfg_stop2;
        l_gap    <= cfg_gap;
      end else begin
        case (state)
          START: if (bit_end) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
          DATA: if (bit_end) begin
            shreg <= shreg >> 1;
            if (bit_cnt == {12'd0, l_dbits} - 16'd1) begin
              bit_cnt <= '0;
              state   <= (l_par != 2'b00) ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 16'd1;
            end
          end
          PARITY: if (bit_end) begin
            state   <= STOP;
            bit_cnt <= '0;
          end
          STOP: if (bit_end) begin
            if (!stop_done) begin
              bit_cnt <= bit_cnt + 16'd1;
            end else if (gap_go) begin
              state   <= GAP;
              bit_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end
          GAP: if (bit_end) begin
            if (gap_done) state <= IDLE;
            else          bit_cnt <= bit_cnt + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gj_axis_uart_tx_fifo.sv
// tb/tb_gj_axis_uart_tx_fifo.sv - self-checking bench for gj_axis_uart_tx_fifo
// Fixed framing vectors, FIFO fill, gap, reset and randomized streams against a bit-level model.
module tb_gj_axis_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cfg_div;
  logic [3:0]  cfg_dbits;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic [15:0] cfg_gap;
  logic        tx_tvalid;
  logic        tx_tready;
  logic [7:0]  tx_tdata;
  logic        tx_tlast;
  logic        tx;
  logic        busy;
  logic [4:0]  fifo_level;

  int checks = 0;
  int errors = 0;
  int n_pushed = 0;

  typedef struct {
    int         div;
    int         dbits;
    int         par;
    bit         stop2;
    int         gap;
    logic [7:0] data;
    bit         last;
  } item_t;

  typedef struct {
    int          div;
    int          dbits;
    int          par;
    bit          stop2;
    logic [7:0]  data;
    logic [15:0] exp;
    int          n;
  } vec_t;

  item_t sb[$];
  item_t pend[$];
  vec_t  vecs[7];

  gj_axis_uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(16), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_div(cfg_div), .cfg_dbits(cfg_dbits),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .cfg_gap(cfg_gap),
    .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tdata(tx_tdata),
    .tx_tlast(tx_tlast), .tx(tx), .busy(busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line image of one character, first transmitted bit at index len-1
  function automatic void char_wave(input item_t it, output logic [63:0] w, output int len);
    int nb, ones;
    nb = (it.dbits < 5) ? 5 : ((it.dbits > 8) ? 8 : it.dbits);
    w = '0; len = 0; ones = 0;
    w = {w[62:0], 1'b0}; len++;
    for (int i = 0; i < nb; i++) begin
      w = {w[62:0], it.data[i]}; len++;
      ones += int'(it.data[i]);
    end
    if (it.par == 1) begin w = {w[62:0], ((ones % 2) == 0)}; len++; end
    if (it.par == 2) begin w = {w[62:0], ((ones % 2) == 1)}; len++; end
    if (it.par == 3) begin w = {w[62:0], 1'b1}; len++; end
    w = {w[62:0], 1'b1}; len++;
    if (it.stop2) begin w = {w[62:0], 1'b1}; len++; end
    if (it.last) for (int g = 0; g < it.gap; g++) begin w = {w[62:0], 1'b1}; len++; end
  endfunction

  task automatic set_cfg(input int div, input int dbits, input int par, input bit stop2, input int gap);
    cfg_div = 16'(div); cfg_dbits = 4'(dbits); cfg_parity = 2'(par);
    cfg_stop2 = stop2; cfg_gap = 16'(gap);
  endtask

  task automatic push_items();
    logic acc;
    int   t;
    @(posedge clk); #1;
    while (pend.size() > 0) begin
      tx_tdata = pend[0].data; tx_tlast = pend[0].last; tx_tvalid = 1'b1;
      t = 0; acc = 1'b0;
      while (!acc && t < 30000) begin
        @(negedge clk) acc = tx_tready;
        @(posedge clk); t++;
      end
      #1;
      if (!acc) begin
        chk("push timeout", 32'(t), 32'(0));
        pend.delete();
      end else begin
        sb.push_back(pend.pop_front());
        n_pushed++;
      end
    end
    tx_tvalid = 1'b0;
  endtask

  // Characters must follow each other with no idle clocks; the line then rests idle
  task automatic check_stream(input int n, input string name);
    int          t, len, bad;
    bit          first;
    logic [63:0] w;
    item_t       it;
    t = 0;
    @(negedge clk);
    while (tx !== 1'b0 && t < 5000) begin @(negedge clk); t++; end
    if (tx !== 1'b0) begin
      chk({name, " start timeout"}, 32'(tx), 32'(0));
      return;
    end
    first = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (sb.size() == 0) begin
        chk({name, " char count"}, 32'(k), 32'(n));
        return;
      end
      it = sb.pop_front();
      char_wave(it, w, len);
      bad = 0;
      for (int b = len - 1; b >= 0; b--) begin
        for (int c = 0; c <= it.div; c++) begin
          if (!first) @(negedge clk);
          first = 1'b0;
          if (tx !== w[b]) bad++;
        end
      end
      chk($sformatf("%s char %0d bad clocks", name, k), 32'(bad), 32'(0));
    end
    @(negedge clk);
    chk({name, " end tx/busy/level"}, {tx, busy, 3'b0, fifo_level}, {1'b1, 1'b0, 3'b0, 5'd0});
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic rdy, t0, t1;
    int   bad;
    set_cfg(v.div, v.dbits, v.par, v.stop2, 0);
    @(posedge clk); #1;
    tx_tdata = v.data; tx_tlast = 1'b0; tx_tvalid = 1'b1;
    @(negedge clk) rdy = tx_tready;
    @(posedge clk); #1;
    tx_tvalid = 1'b0;
    chk($sformatf("vec%0d accept", idx), 32'(rdy), 32'(1));
    @(negedge clk) t0 = tx;
    @(negedge clk) t1 = tx;
    // Character has been latched; later cfg changes must not disturb it
    set_cfg($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom), 5);
    chk($sformatf("vec%0d start latency", idx), {t0, t1}, 2'b11);
    bad = 0;
    for (int b = v.n - 1; b >= 0; b--)
      for (int c = 0; c <= v.div; c++) begin
        @(negedge clk);
        if (tx !== v.exp[b]) bad++;
      end
    chk($sformatf("vec%0d wave bad clocks", idx), 32'(bad), 32'(0));
    @(negedge clk);
    chk($sformatf("vec%0d idle tx/busy", idx), {tx, busy}, 2'b10);
  endtask

  initial begin
    // div dbits par stop2 data, expected line bits left-to-right in time order
    vecs[0] = '{3, 8,  0, 1'b0, 8'hA5, 16'b0101001011,   10};
    vecs[1] = '{1, 7,  2, 1'b1, 8'h53, 16'b01100101011,  11};
    vecs[2] = '{0, 5,  1, 1'b0, 8'h1F, 16'b01111101,     8};
    vecs[3] = '{0, 5,  1, 1'b0, 8'hFF, 16'b01111101,     8};
    vecs[4] = '{2, 12, 3, 1'b1, 8'h3C, 16'b000111100111, 12};
    vecs[5] = '{1, 2,  2, 1'b1, 8'h0A, 16'b001010011,    9};
    vecs[6] = '{2, 6,  0, 1'b0, 8'hED, 16'b01011011,     8};

    rst = 1'b0; tx_tvalid = 1'b0; tx_tdata = '0; tx_tlast = 1'b0;
    set_cfg(3, 8, 0, 1'b0, 0);
    repeat (3) @(negedge clk);
    chk("reset tx", 32'(tx), 32'(1));
    chk("reset tready", 32'(tx_tready), 32'(0));
    chk("reset busy", 32'(busy), 32'(0));
    chk("reset level", 32'(fifo_level), 32'(0));
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk) chk("tready before first edge", 32'(tx_tready), 32'(0));
    @(negedge clk) chk("tready after first edge", 32'(tx_tready), 32'(1));

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // FIFO fill with a slow shifter: 17 accepted, one popped, then full
    set_cfg(100, 8, 0, 1'b0, 0);
    sb.delete(); n_pushed = 0;
    for (int i = 0; i < 18; i++) pend.push_back('{100, 8, 0, 1'b0, 0, 8'($urandom), 1'b0});
    fork
      push_items();
      check_stream(18, "fill");
      begin
        int t = 0;
        @(negedge clk);
        while (n_pushed < 17 && t < 200) begin @(negedge clk); t++; end
        chk("full level", 32'(fifo_level), 32'(16));
        chk("full tready", 32'(tx_tready), 32'(0));
      end
    join

    // Gap after a tlast character, none after a plain one
    set_cfg(2, 8, 0, 1'b0, 3);
    sb.delete();
    pend.push_back('{2, 8, 0, 1'b0, 3, 8'h41, 1'b1});
    pend.push_back('{2, 8, 0, 1'b0, 3, 8'h42, 1'b0});
    pend.push_back('{2, 8, 0, 1'b0, 3, 8'h43, 1'b1});
    fork
      push_items();
      check_stream(3, "gap");
    join

    // Reset in the middle of data bit 3 with characters still queued
    set_cfg(3, 8, 0, 1'b0, 0);
    @(posedge clk); #1;
    tx_tvalid = 1'b1; tx_tdata = 8'h00; tx_tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1 tx_tvalid = 1'b0;
    begin
      int t = 0;
      while (tx !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    end
    repeat (16) @(negedge clk);
    chk("pre-reset level", 32'(fifo_level), 32'(2));
    #1 rst = 1'b0;
    #1;
    chk("async reset tx", 32'(tx), 32'(1));
    chk("async reset tready", 32'(tx_tready), 32'(0));
    chk("async reset level", 32'(fifo_level), 32'(0));
    chk("async reset busy", 32'(busy), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    run_vec(vecs[0], 7);

    // Randomized batches, each with one configuration
    for (int r = 0; r < 6; r++) begin
      int div, db, par, gap, n;
      bit st;
      div = $urandom_range(0, 3); db = $urandom_range(0, 15); par = $urandom_range(0, 3);
      st = 1'($urandom); gap = $urandom_range(0, 3); n = $urandom_range(1, 8);
      set_cfg(div, db, par, st, gap);
      sb.delete();
      for (int i = 0; i < n; i++) pend.push_back('{div, db, par, st, gap, 8'($urandom), 1'($urandom)});
      fork
        push_items();
        check_stream(n, $sformatf("rand%0d", r));
      join
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
